// File: rtl/eeprom_programmer.sv
// eeprom_programmer: paged parallel-EEPROM byte/page writer with DQ7 data polling.
// Ports: clk, nrst (async active-low reset);
//        wr_valid/wr_ready/wr_addr/wr_data/wr_last byte stream in;
//        busy, done (one-clock pulse), err (sticky polling timeout) status out;
//        ee_addr, ee_dq_out, ee_dq_oe, ee_dq_in, ee_nce, ee_nwe, ee_noe EEPROM pins.
// Build option: define EEPROM_SDP_EN to prefix every page started from IDLE with
//        the three-cycle software-data-protection unlock sequence.
module eeprom_programmer #(
    parameter int SETUP_CYC   = 2,
    parameter int WE_LOW_CYC  = 4,
    parameter int WE_HIGH_CYC = 2,
    parameter int BLC_CYC     = 1000,
    parameter int POLL_CYC    = 2,
    parameter int TIMEOUT_CYC = 20000
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [14:0] wr_addr,
    input  logic [7:0]  wr_data,
    input  logic        wr_last,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [14:0] ee_addr,
    output logic [7:0]  ee_dq_out,
    output logic        ee_dq_oe,
    input  logic [7:0]  ee_dq_in,
    output logic        ee_nce,
    output logic        ee_nwe,
    output logic        ee_noe
);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] SETUP     = 3'd1;
    localparam logic [2:0] WE_LOW    = 3'd2;
    localparam logic [2:0] WE_HIGH   = 3'd3;
    localparam logic [2:0] WAIT_NEXT = 3'd4;
    localparam logic [2:0] POLL_LOW  = 3'd5;
    localparam logic [2:0] POLL_HIGH = 3'd6;
    localparam logic [2:0] DONE      = 3'd7;

    logic [2:0]  state;
    logic [31:0] cnt;
    logic [31:0] tcnt;
    logic [8:0]  page;
    logic [7:0]  data_q;
    logic        last_q;
    logic        same_page;
    logic        polling;
    logic        timeout;
`ifdef EEPROM_SDP_EN
    logic [1:0]  unlock;
    logic [14:0] addr_q;
`endif

    assign same_page = wr_addr[14:6] == page;
    assign wr_ready  = state == IDLE || (state == WAIT_NEXT && (!wr_valid || same_page));
    assign polling   = state == POLL_LOW || state == POLL_HIGH;
    assign timeout   = polling && tcnt == 32'(TIMEOUT_CYC - 1);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            cnt       <= '0;
            tcnt      <= '0;
            page      <= '0;
            data_q    <= '0;
            last_q    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            ee_addr   <= '0;
            ee_dq_out <= '0;
            ee_dq_oe  <= 1'b0;
            ee_nce    <= 1'b1;
            ee_nwe    <= 1'b1;
            ee_noe    <= 1'b1;
`ifdef EEPROM_SDP_EN
            unlock    <= '0;
            addr_q    <= '0;
`endif
        end else begin
            done <= 1'b0;
            if (timeout) begin
                state  <= IDLE;
                busy   <= 1'b0;
                err    <= 1'b1;
                ee_nce <= 1'b1;
                ee_noe <= 1'b1;
                cnt    <= '0;
                tcnt   <= '0;
            end else begin
                if (polling)
                    tcnt <= tcnt + 32'd1;
                case (state)
                    IDLE: if (wr_valid) begin
                        page     <= wr_addr[14:6];
                        data_q   <= wr_data;
                        last_q   <= wr_last;
                        err      <= 1'b0;
                        busy     <= 1'b1;
                        ee_nce   <= 1'b0;
                        ee_dq_oe <= 1'b1;
                        cnt      <= '0;
                        state    <= SETUP;
`ifdef EEPROM_SDP_EN
                        // User byte is parked until the unlock cycles have gone out.
                        addr_q    <= wr_addr;
                        unlock    <= 2'd3;
                        ee_addr   <= 15'h5555;
                        ee_dq_out <= 8'hAA;
`else
                        ee_addr   <= wr_addr;
                        ee_dq_out <= wr_data;
`endif
                    end
                    SETUP: if (cnt == 32'(SETUP_CYC - 1)) begin
                        cnt    <= '0;
                        ee_nwe <= 1'b0;
                        state  <= WE_LOW;
                    end else
                        cnt <= cnt + 32'd1;
                    WE_LOW: if (cnt == 32'(WE_LOW_CYC - 1)) begin
                        cnt    <= '0;
                        ee_nwe <= 1'b1;
                        state  <= WE_HIGH;
                    end else
                        cnt <= cnt + 32'd1;
                    WE_HIGH: if (cnt == 32'(WE_HIGH_CYC - 1)) begin
                        cnt <= '0;
`ifdef EEPROM_SDP_EN
                        if (unlock != 2'd0) begin
                            unlock    <= unlock - 2'd1;
                            state     <= SETUP;
                            ee_addr   <= unlock == 2'd3 ? 15'h2AAA : unlock == 2'd2 ? 15'h5555 : addr_q;
                            ee_dq_out <= unlock == 2'd3 ? 8'h55 : unlock == 2'd2 ? 8'hA0 : data_q;
                        end else
`endif
                        if (last_q) begin
                            state    <= POLL_LOW;
                            ee_dq_oe <= 1'b0;
                            ee_noe   <= 1'b0;
                            tcnt     <= '0;
                        end else
                            state <= WAIT_NEXT;
                    end else
                        cnt <= cnt + 32'd1;
                    WAIT_NEXT: if (wr_valid && same_page) begin
                        data_q    <= wr_data;
                        last_q    <= wr_last;
                        ee_addr   <= wr_addr;
                        ee_dq_out <= wr_data;
                        err       <= 1'b0;
                        cnt       <= '0;
                        state     <= SETUP;
                    end else if (wr_valid || cnt == 32'(BLC_CYC - 1)) begin
                        // Foreign page or expired byte-load window: close the page without accepting.
                        cnt      <= '0;
                        tcnt     <= '0;
                        ee_dq_oe <= 1'b0;
                        ee_noe   <= 1'b0;
                        state    <= POLL_LOW;
                    end else
                        cnt <= cnt + 32'd1;
                    POLL_LOW: if (cnt == 32'(POLL_CYC - 1)) begin
                        cnt    <= '0;
                        ee_noe <= 1'b1;
                        if (ee_dq_in[7] == data_q[7]) begin
                            done   <= 1'b1;
                            ee_nce <= 1'b1;
                            state  <= DONE;
                        end else
                            state <= POLL_HIGH;
                    end else
                        cnt <= cnt + 32'd1;
                    POLL_HIGH: begin
                        ee_noe <= 1'b0;
                        state  <= POLL_LOW;
                    end
                    DONE: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
